// File: rtl/bridge_decode_fanout.sv
// Bridge fan-out: decodes one master port onto NUM_SLAVES windowed slave ports
// with registered strobes and a latency-tracked registered read-return mux.

module bdf_win_match #(
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] MASK   = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);
    assign hit = (addr & MASK) == (BASE & MASK);
endmodule

module bridge_decode_fanout #(
    parameter int                             NUM_SLAVES   = 4,
    parameter int                             ADDR_W       = 32,
    parameter int                             DATA_W       = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   BASES        = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   MASKS        = {NUM_SLAVES{32'hFFFF0000}},
    parameter int                             SLAVE_RD_LAT = 1,
    parameter logic [DATA_W-1:0]              DEFAULT_RD   = 32'hFFFFFFFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wr_data,
    input  logic                         m_wr,
    input  logic                         m_rd,
    output logic [DATA_W-1:0]            m_rd_data,
    output logic                         m_rd_valid,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wr_data,
    output logic [NUM_SLAVES-1:0]        s_wr,
    output logic [NUM_SLAVES-1:0]        s_rd,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
    output logic [15:0]                  unmapped_count
);
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int STAGES = SLAVE_RD_LAT;

    typedef struct packed {
        logic             unm;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [NUM_SLAVES-1:0]             hit;
    logic [NUM_SLAVES-1:0]             sel_oh;
    logic [IDX_W-1:0]                  sel;
    logic                              found;
    logic                              acc, bad, rd_acc;
    logic [STAGES:0]                   vld_pipe;
    tag_t [STAGES:0]                   tag_pipe;
    tag_t                              tail;
    logic [NUM_SLAVES-1:0][DATA_W-1:0] s_rd_vec;

    assign s_rd_vec = s_rd_data;

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_win
        bdf_win_match #(
            .ADDR_W (ADDR_W),
            .BASE   (BASES[i*ADDR_W +: ADDR_W]),
            .MASK   (MASKS[i*ADDR_W +: ADDR_W])
        ) u_win (
            .addr (m_addr),
            .hit  (hit[i])
        );
    end

    // Walk downward so the lowest matching index is the one left standing.
    always_comb begin
        sel    = '0;
        found  = 1'b0;
        sel_oh = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel   = IDX_W'(i);
                found = 1'b1;
            end
        end
        sel_oh[sel] = found;
    end

    assign acc    = m_wr | m_rd;
    assign bad    = (m_wr & m_rd) | (acc & ~found);
    assign rd_acc = m_rd & ~m_wr;
    assign tail   = tag_pipe[STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_addr         <= '0;
            s_wr_data      <= '0;
            s_wr           <= '0;
            s_rd           <= '0;
            unmapped_count <= '0;
        end else begin
            if (acc) begin
                s_addr    <= m_addr;
                s_wr_data <= m_wr_data;
            end
            s_wr <= m_wr   ? sel_oh : '0;
            s_rd <= rd_acc ? sel_oh : '0;
            if (bad && unmapped_count != 16'hFFFF)
                unmapped_count <= unmapped_count + 16'd1;
        end
    end

    // Unmapped reads still ride the pipeline so the master always gets a return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            tag_pipe[0] <= '{unm: ~found, idx: sel};
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rd_data  <= '0;
            m_rd_valid <= 1'b0;
        end else begin
            m_rd_valid <= vld_pipe[STAGES];
            if (vld_pipe[STAGES])
                m_rd_data <= tail.unm ? DEFAULT_RD : s_rd_vec[tail.idx];
        end
    end
endmodule

// File: tb/tb_bridge_decode_fanout.sv
// Bench for bridge_decode_fanout: scoreboarded reads, strobe/decode checks,
// unmapped counting and saturation, async reset, and an overlapping-window instance.

module tb_bridge_decode_fanout;
    localparam int NS = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [31:0]          m_addr, m_wr_data;
    logic                 m_wr, m_rd;
    logic [31:0]          m_rd_data;
    logic                 m_rd_valid;
    logic [31:0]          s_addr, s_wr_data;
    logic [NS-1:0]        s_wr, s_rd;
    logic [NS-1:0][31:0]  slv_q;
    logic [15:0]          unmapped_count;

    logic [31:0]          o_m_rd_data, o_s_addr, o_s_wr_data;
    logic                 o_m_rd_valid;
    logic [1:0]           o_s_wr, o_s_rd;
    logic [63:0]          o_s_rd_data = '0;
    logic [15:0]          o_cnt;

    logic [31:0]          rd_base [NS];

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc  = 0;
    int   nchk = 0;
    int   nerr = 0;

    bridge_decode_fanout #(
        .NUM_SLAVES   (NS),
        .BASES        ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_RD_LAT (1)
    ) dut (
        .clk (clk), .reset (reset),
        .m_addr (m_addr), .m_wr_data (m_wr_data), .m_wr (m_wr), .m_rd (m_rd),
        .m_rd_data (m_rd_data), .m_rd_valid (m_rd_valid),
        .s_addr (s_addr), .s_wr_data (s_wr_data), .s_wr (s_wr), .s_rd (s_rd),
        .s_rd_data (slv_q), .unmapped_count (unmapped_count)
    );

    // Slave 1's window fully covers slave 0's, so priority decides.
    bridge_decode_fanout #(
        .NUM_SLAVES (2),
        .BASES      ({32'h0000_0000, 32'h0000_0000}),
        .MASKS      ({32'hF000_0000, 32'hFFFF_0000})
    ) dut_ovl (
        .clk (clk), .reset (reset),
        .m_addr (m_addr), .m_wr_data (m_wr_data), .m_wr (m_wr), .m_rd (m_rd),
        .m_rd_data (o_m_rd_data), .m_rd_valid (o_m_rd_valid),
        .s_addr (o_s_addr), .s_wr_data (o_s_wr_data), .s_wr (o_s_wr), .s_rd (o_s_rd),
        .s_rd_data (o_s_rd_data), .unmapped_count (o_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slaves answer exactly one cycle after s_rd; garbage otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++)
            slv_q[i] <= s_rd[i] ? rd_base[i] : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("rd_spurious", {31'b0, m_rd_valid}, 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rd_data", m_rd_data, mon_e.d);
                chk("rd_cycle", 32'(cyc), 32'(mon_e.c));
            end
        end
    end

    task automatic acc(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        m_wr = wr; m_rd = rd; m_addr = a; m_wr_data = d;
        @(posedge clk); #1;
        m_wr = 1'b0; m_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd_exp(input logic [31:0] a, input logic [31:0] d);
        sb_q.push_back('{d: d, c: cyc + 3});
        acc(1'b0, 1'b1, a, 32'h0);
    endtask

    initial begin
        rd_base[0] = 32'h1111_0000;
        rd_base[1] = 32'h2222_0001;
        rd_base[2] = 32'h1234_5678;
        rd_base[3] = 32'h4444_0003;
        m_addr = '0; m_wr_data = '0; m_wr = 1'b0; m_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_rd_data", m_rd_data, 32'h0);
        chk("rst_m_rd_valid", {31'b0, m_rd_valid}, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wr_data", s_wr_data, 32'h0);
        chk("rst_s_wr", {28'b0, s_wr}, 32'h0);
        chk("rst_s_rd", {28'b0, s_rd}, 32'h0);
        chk("rst_count", {16'b0, unmapped_count}, 32'h0);
        reset = 1'b0;
        idle(2);

        acc(1'b1, 1'b0, 32'h1000_0004, 32'hA5A5_0001);
        chk("wr_s_wr", {28'b0, s_wr}, 32'h2);
        chk("wr_s_rd", {28'b0, s_rd}, 32'h0);
        chk("wr_s_addr", s_addr, 32'h1000_0004);
        chk("wr_s_wr_data", s_wr_data, 32'hA5A5_0001);
        idle(1);
        chk("wr_s_wr_clear", {28'b0, s_wr}, 32'h0);
        chk("wr_s_addr_hold", s_addr, 32'h1000_0004);

        rd_exp(32'h2000_0008, rd_base[2]);
        chk("rd_s_rd", {28'b0, s_rd}, 32'h4);
        chk("rd_s_addr", s_addr, 32'h2000_0008);
        idle(4);

        for (int i = 0; i < NS; i++)
            rd_exp(32'h1000_0000 * i + 32'h40, rd_base[i]);
        idle(5);
        chk("rd_data_hold", m_rd_data, rd_base[3]);
        chk("b2b_count", {16'b0, unmapped_count}, 32'h0);

        rd_exp(32'h8000_0000, 32'hFFFF_FFFF);
        chk("unm_rd_s_rd", {28'b0, s_rd}, 32'h0);
        chk("unm_rd_count", {16'b0, unmapped_count}, 32'h1);
        idle(4);

        acc(1'b1, 1'b1, 32'h1000_0010, 32'h5555_AAAA);
        chk("wrrd_s_wr", {28'b0, s_wr}, 32'h2);
        chk("wrrd_s_rd", {28'b0, s_rd}, 32'h0);
        chk("wrrd_count", {16'b0, unmapped_count}, 32'h2);
        idle(4);

        acc(1'b1, 1'b0, 32'h9000_0000, 32'h0);
        chk("unm_wr_s_wr", {28'b0, s_wr}, 32'h0);
        chk("unm_wr_count", {16'b0, unmapped_count}, 32'h3);

        rd_exp(32'h0000_1234, rd_base[0]);
        chk("ovl_s_rd", {30'b0, o_s_rd}, 32'h1);
        chk("ovl_main_s_rd", {28'b0, s_rd}, 32'h1);
        idle(4);

        acc(1'b0, 1'b1, 32'h3000_0000, 32'h0);
        reset = 1'b1;
        #1;
        sb_q.delete();
        chk("arst_m_rd_data", m_rd_data, 32'h0);
        chk("arst_s_rd", {28'b0, s_rd}, 32'h0);
        chk("arst_s_addr", s_addr, 32'h0);
        chk("arst_count", {16'b0, unmapped_count}, 32'h0);
        idle(2);
        reset = 1'b0;
        idle(6);
        chk("arst_rdata_after", m_rd_data, 32'h0);

        m_addr = 32'h8000_0000; m_wr = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", {16'b0, unmapped_count}, 32'hFFFE);
        repeat (70000 - 65534) @(posedge clk);
        #1;
        m_wr = 1'b0;
        chk("sat_ffff", {16'b0, unmapped_count}, 32'hFFFF);
        idle(3);
        chk("sat_hold", {16'b0, unmapped_count}, 32'hFFFF);

        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/bridge_decode_fanout.md
Name: bridge_decode_fanout

Overview:
- Parametrised bridge fan-out: one bridge master port drives NUM_SLAVES slave ports.
- Each slave owns an address window (base/mask). The block registers the request toward the selected slave.
- Read data comes back through a latency-tracked, registered return mux. Unmapped accesses are counted.
- Sits between the pocket bridge endpoint and the core's register and memory blocks, replacing hand-wired one-to-one master/slave connections.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- ADDR_W, 32, bridge address width.
- DATA_W, 32, bridge data width.
- BASES, {NUM_SLAVES{32'h0}}, packed NUM_SLAVES*ADDR_W; base of window i in slice i.
- MASKS, {NUM_SLAVES{32'hFFFF0000}}, packed; slave i matches when (m_addr & MASKS[i]) == (BASES[i] & MASKS[i]).
- SLAVE_RD_LAT, 1, cycles from s_rd to valid s_rd_data at every slave (0..7).
- DEFAULT_RD, 32'hFFFFFFFF, read data returned for an unmapped read.

Ports:
- clk, in, 1, bridge clock.
- reset, in, 1, asynchronous active-high reset.
- m_addr, in, ADDR_W, master address.
- m_wr_data, in, DATA_W, master write data.
- m_wr, in, 1, master write strobe (1 cycle per access).
- m_rd, in, 1, master read strobe (1 cycle per access).
- m_rd_data, out, DATA_W, registered read return.
- m_rd_valid, out, 1, 1-cycle pulse when m_rd_data updates.
- s_addr, out, ADDR_W, registered address, common to all slaves.
- s_wr_data, out, DATA_W, registered write data, common to all slaves.
- s_wr, out, NUM_SLAVES, one-hot registered write strobes.
- s_rd, out, NUM_SLAVES, one-hot registered read strobes.
- s_rd_data, in, NUM_SLAVES*DATA_W, packed slave read data; slice i from slave i.
- unmapped_count, out, 16, saturating count of unmapped or illegal accesses.

Behaviour:
- Reset (async assert, sync deassert by user):
  - All outputs 0, including m_rd_data, m_rd_valid, s_* and unmapped_count.
  - Read-tracking pipeline cleared.
- Decode (combinational on m_addr):
  - Hit vector computed from MASKS/BASES.
  - On multiple hits the lowest index wins. No hit means unmapped.
- Request stage, registered, cycle T -> T+1:
  - s_addr and s_wr_data load on any cycle where m_wr or m_rd is high; otherwise they hold.
  - s_wr[sel] = m_wr and s_rd[sel] = m_rd for the winning slave. All other bits 0.
  - Strobes are high for exactly 1 cycle.
- Write + read in the same cycle:
  - Write is performed; read is dropped (no s_rd, no m_rd_valid).
  - unmapped_count += 1.
- Unmapped write: no s_wr bit set; unmapped_count += 1.
- Unmapped read:
  - No s_rd bit set; unmapped_count += 1.
  - A read is still tracked, with the return forced to DEFAULT_RD.
- Read tracking:
  - Shift pipeline of depth SLAVE_RD_LAT+1.
  - Each entry holds {valid, unmapped flag, slave index}.
  - Loads at T+1 alongside s_rd and advances every cycle.
- Return stage:
  - When the pipeline tail is valid, m_rd_data is registered from the s_rd_data slice of the tracked index, or DEFAULT_RD if unmapped.
  - m_rd_valid pulses for that cycle.
  - Otherwise m_rd_data holds its last value.
- Latency: read strobe at T gives m_rd_data/m_rd_valid at T+SLAVE_RD_LAT+2. Writes reach the slave at T+1.
- Back-to-back reads on consecutive cycles are fully pipelined: one return per cycle, in order. No stall and no backpressure.
- unmapped_count saturates at 16'hFFFF and never wraps.
- Reset mid-read: in-flight reads are discarded; no m_rd_valid after reset release.

Test Plan:
- Defaults, 4 slaves at 0x0000_0000/0x1000_0000/0x2000_0000/0x3000_0000:
  - Write 0x1000_0004 data 0xA5A5_0001 -> at T+1 s_wr=4'b0010, s_addr=0x1000_0004, s_wr_data=0xA5A5_0001.
  - All s_* strobes are 0 at T+2.
- Read 0x2000_0008, slave 2 returns 0x1234_5678 one cycle after s_rd -> m_rd_valid and m_rd_data=0x1234_5678 at T+3.
- Four consecutive reads to slaves 0, 1, 2, 3 on T..T+3 -> four consecutive m_rd_valid pulses T+3..T+6 with each slave's data, in order.
- Read 0x8000_0000 (unmapped) -> s_rd=0; m_rd_data=0xFFFF_FFFF with m_rd_valid at T+3; unmapped_count=1.
- m_wr and m_rd high together to slave 1:
  - s_wr=4'b0010, s_rd=0, no m_rd_valid; unmapped_count increments.
  - 70000 unmapped writes -> count sticks at 16'hFFFF.
- Assert reset one cycle after a read strobe -> all outputs 0 immediately (async), no m_rd_valid after release. Overlapping windows (MASKS overlap slaves 0 and 1) -> only s_rd[0] fires.
